// File: rtl/demod_pkg.sv
// Shared demodulator definitions: Q16.16 reference levels, packer FSM states
// and default packer geometry.
package demod_pkg;

  localparam logic [31:0] ONE_Q16  = 32'h0001_0000;
  localparam logic [31:0] MONE_Q16 = 32'hFFFF_0000;

  localparam int NSEG_DEF = 10;
  localparam int DW_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/demod_hard_slicer.sv
// Combinational hard decision on one signed segment sample: bit is 1 only for
// strictly positive values; zero_o flags an exact zero (no reference match).
module demod_hard_slicer #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] data_i,
  output logic          bit_o,
  output logic          zero_o
);

  assign zero_o = (data_i == '0);
  assign bit_o  = !data_i[DW-1] && !zero_o;

endmodule

// File: rtl/demod_bit_packer.sv
// Packs NSEG sliced segment decisions (segment 0 at bit 0) into one word and
// hands it off over valid/ready. Define ERASE_FLAG_EN to add the erase_mask port.
module demod_bit_packer
  import demod_pkg::*;
#(
  parameter int NSEG = NSEG_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DW-1:0]   seg_data,
  input  logic            seg_valid,
  output logic [NSEG-1:0] bits_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            overrun,
  output logic [15:0]     frame_cnt,
`ifdef ERASE_FLAG_EN
  output logic [NSEG-1:0] erase_mask,
`endif
  output logic [1:0]      dbg_state_o
);

  localparam int IW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSEG - 1);

  // Handshake: bits_out is offered while out_valid is high and is held stable
  // until the cycle in which out_ready is also high; that edge completes the transfer.

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NSEG-1:0] word_q, word_d;
  logic [NSEG-1:0] bits_out_q, bits_out_d;
  logic            out_valid_q, out_valid_d;
  logic            overrun_q, overrun_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            busy_q;
  logic            seg_bit, seg_zero;
`ifdef ERASE_FLAG_EN
  logic [NSEG-1:0] ers_word_q, ers_word_d;
  logic [NSEG-1:0] erase_mask_q, erase_mask_d;
`endif

  demod_hard_slicer #(.DW(DW)) u_slicer (
    .data_i (seg_data),
    .bit_o  (seg_bit),
    .zero_o (seg_zero)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    bits_out_d  = bits_out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
`ifdef ERASE_FLAG_EN
    ers_word_d   = ers_word_q;
    erase_mask_d = erase_mask_q;
`endif
    if (start) begin
      // A start abandons everything in flight; a beat in the same cycle is segment 0.
      state_d     = COLLECT;
      idx_d       = '0;
      word_d      = '0;
      bits_out_d  = '0;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef ERASE_FLAG_EN
      ers_word_d   = '0;
      erase_mask_d = '0;
`endif
      if (seg_valid) begin
        word_d[0] = seg_bit;
        idx_d     = IW'(1);
`ifdef ERASE_FLAG_EN
        ers_word_d[0] = seg_zero;
`endif
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (seg_valid) overrun_d = 1'b1;
        end
        COLLECT: begin
          if (seg_valid) begin
            word_d[idx_q] = seg_bit;
`ifdef ERASE_FLAG_EN
            ers_word_d[idx_q] = seg_zero;
`endif
            if (idx_q == LAST_IDX) begin
              bits_out_d  = word_d;
              out_valid_d = 1'b1;
              state_d     = HOLD;
              idx_d       = '0;
              word_d      = '0;
`ifdef ERASE_FLAG_EN
              erase_mask_d = ers_word_d;
              ers_word_d   = '0;
`endif
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        HOLD: begin
          if (seg_valid) overrun_d = 1'b1;
          if (out_valid_q && out_ready) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            out_valid_d = 1'b0;
            idx_d       = '0;
            state_d     = COLLECT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      word_q      <= '0;
      bits_out_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
`ifdef ERASE_FLAG_EN
      ers_word_q   <= '0;
      erase_mask_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      bits_out_q  <= bits_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= (state_d != IDLE);
`ifdef ERASE_FLAG_EN
      ers_word_q   <= ers_word_d;
      erase_mask_q <= erase_mask_d;
`endif
    end
  end

  assign bits_out    = bits_out_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign frame_cnt   = frame_cnt_q;
  assign dbg_state_o = state_q;
`ifdef ERASE_FLAG_EN
  assign erase_mask  = erase_mask_q;
`endif

endmodule

// File: tb/tb_demod_bit_packer.sv
// Directed bench for demod_bit_packer (NSEG=10, DW=32); the erase-mask vector
// is compiled in only when ERASE_FLAG_EN is defined.
module tb_demod_bit_packer;
  import demod_pkg::*;

  localparam int NSEG = 10;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [DW-1:0]   seg_data = '0;
  logic            seg_valid = 1'b0;
  logic [NSEG-1:0] bits_out;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            busy;
  logic            overrun;
  logic [15:0]     frame_cnt;
  logic [1:0]      dbg_state;
`ifdef ERASE_FLAG_EN
  logic [NSEG-1:0] erase_mask;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [NSEG-1:0] exp_q[$];

  demod_bit_packer #(.NSEG(NSEG), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .seg_data   (seg_data),
    .seg_valid  (seg_valid),
    .bits_out   (bits_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun),
    .frame_cnt  (frame_cnt),
`ifdef ERASE_FLAG_EN
    .erase_mask (erase_mask),
`endif
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: every completed handshake must match the next expected word
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", {22'd0, bits_out}, 32'hDEAD);
      else chk("word", {22'd0, bits_out}, {22'd0, exp_q.pop_front()});
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic with_beat, input logic [DW-1:0] d);
    start = 1'b1;
    seg_valid = with_beat;
    seg_data = d;
    tick();
    start = 1'b0;
    seg_valid = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d);
    seg_valid = 1'b1;
    seg_data = d;
    tick();
    seg_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] lvl(input logic b);
    return b ? ONE_Q16 : MONE_Q16;
  endfunction

  initial begin
    // 1: reset, then asynchronous reset in the middle of COLLECT
    repeat (3) tick();
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 0);
    reset = 1'b1;
    tick();
    pulse_start(1'b0, '0);
    chk("start_busy", {31'd0, busy}, 1);
    for (int i = 0; i < 3; i++) beat(ONE_Q16);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 0);
    chk("async_rst_bits", {22'd0, bits_out}, 0);
    chk("async_rst_overrun", {31'd0, overrun}, 0);
    chk("async_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) beat(ONE_Q16);
    chk("idle_no_valid", {31'd0, out_valid}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_overrun", {31'd0, overrun}, 1);

    // 2: alternating +1/-1, ready high
    out_ready = 1'b1;
    pulse_start(1'b0, '0);
    chk("start_clears_overrun", {31'd0, overrun}, 0);
    exp_q.push_back(10'b0101010101);
    for (int i = 0; i < NSEG; i++) beat(lvl(i % 2 == 0));
    chk("alt_valid", {31'd0, out_valid}, 1);
    chk("alt_bits", {22'd0, bits_out}, 32'h155);
    chk("alt_cnt_before", {16'd0, frame_cnt}, 0);
    tick();
    chk("alt_cnt", {16'd0, frame_cnt}, 1);
    chk("alt_valid_drop", {31'd0, out_valid}, 0);
    chk("alt_state", {30'd0, dbg_state}, {30'd0, COLLECT});

    // 3: back-pressure for 5 cycles with two dropped beats
    out_ready = 1'b0;
    exp_q.push_back(10'h204);
    for (int i = 0; i < NSEG; i++)
      beat((i == 5) ? 32'd0 : lvl(i == 2 || i == 9));
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", {31'd0, out_valid}, 1);
      chk("hold_bits", {22'd0, bits_out}, 32'h204);
      seg_valid = (c < 2);
      seg_data = ONE_Q16;
      tick();
      seg_valid = 1'b0;
    end
    chk("hold_overrun", {31'd0, overrun}, 1);
    chk("hold_cnt", {16'd0, frame_cnt}, 1);
    out_ready = 1'b1;
    tick();
    chk("hold_cnt_after", {16'd0, frame_cnt}, 2);
    tick();
    chk("hold_cnt_once", {16'd0, frame_cnt}, 2);

    // 4: restart after a partial word
    for (int i = 0; i < 4; i++) beat(MONE_Q16);
    pulse_start(1'b0, '0);
    chk("restart_overrun", {31'd0, overrun}, 0);
    exp_q.push_back(10'h3FF);
    for (int i = 0; i < NSEG; i++) beat(ONE_Q16);
    chk("ones_bits", {22'd0, bits_out}, 32'h3FF);
    tick();
    chk("ones_cnt", {16'd0, frame_cnt}, 3);

    // start while a word is pending discards it; start+beat is segment 0
    out_ready = 1'b0;
    for (int i = 0; i < NSEG; i++) beat(MONE_Q16);
    chk("pend_valid", {31'd0, out_valid}, 1);
    pulse_start(1'b0, '0);
    chk("discard_valid", {31'd0, out_valid}, 0);
    chk("discard_cnt", {16'd0, frame_cnt}, 3);
    out_ready = 1'b1;
    exp_q.push_back(10'h001);
    pulse_start(1'b1, ONE_Q16);
    for (int i = 1; i < NSEG; i++) beat(32'd0);
    chk("seg0_bits", {22'd0, bits_out}, 32'h001);
    tick();
    chk("seg0_cnt", {16'd0, frame_cnt}, 4);

    // back-to-back words at full rate: NSEG beats plus one handshake cycle
    exp_q.push_back(10'h01F);
    exp_q.push_back(10'h3E0);
    for (int i = 0; i < NSEG; i++) beat(lvl(i < 5));
    tick();
    for (int i = 0; i < NSEG; i++) beat(lvl(i >= 5));
    chk("b2b_bits", {22'd0, bits_out}, 32'h3E0);
    tick();
    chk("b2b_cnt", {16'd0, frame_cnt}, 6);
    chk("b2b_overrun", {31'd0, overrun}, 0);

    // 5: frame counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    #1;
    chk("wrap_preload", {16'd0, frame_cnt}, 32'hFFFF);
    exp_q.push_back(10'h2AA);
    for (int i = 0; i < NSEG; i++) beat(lvl(i % 2 == 1));
    tick();
    chk("wrap_cnt", {16'd0, frame_cnt}, 0);

`ifdef ERASE_FLAG_EN
    // 6: erasures on segments 3 and 7
    exp_q.push_back(10'h000);
    for (int i = 0; i < NSEG; i++) beat((i == 3 || i == 7) ? 32'd0 : MONE_Q16);
    chk("erase_bits", {22'd0, bits_out}, 0);
    chk("erase_mask", {22'd0, erase_mask}, 32'h088);
    tick();
    chk("erase_cnt", {16'd0, frame_cnt}, 1);
    pulse_start(1'b0, '0);
    chk("erase_start_clr", {22'd0, erase_mask}, 0);
`endif

    repeat (2) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
